// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes, arbiter state encoding and the
//                round-robin pick helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Winner among the two requesters: on contention the one that did not
    // win last time, otherwise whichever single requester is valid.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last);
        if (valid == 2'b11) begin
            return ~last;
        end
        return valid[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu1 / alu
//  Description : 4-bit ripple ALU built from one-bit slices. control[2]
//                inverts B and injects the carry (SUB/SLT); control[1:0]
//                selects AND, OR, SUM or the set-less-than bit.
//  Revision    : 1.0  initial release
// ============================================================================
module alu1 import alu_pkg::*; (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] control,
    output logic       result,
    output logic       cout
);

    logic bb;
    logic sum;

    assign bb   = b ^ control[2];
    assign sum  = a ^ bb ^ cin;
    assign cout = (a & bb) | (cin & (a ^ bb));

    // Output select for this bit position.
    always_comb begin
        result = 1'b0;
        case (control[1:0])
            ALU_AND[1:0]: result = a & bb;
            ALU_OR[1:0]:  result = a | bb;
            ALU_ADD[1:0]: result = sum;
            ALU_SLT[1:0]: result = less;
            default:      result = 1'b0;
        endcase
    end

endmodule

module alu import alu_pkg::*; (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] control,
    output logic [3:0] result,
    output logic       zero
);

    logic set_lt;
    logic unused_msb_cout;

    genvar i;
    for (i = 0; i < 4; i++) begin : g_slice
        logic cin;
        logic cout;
        logic res;

        if (i == 0) begin : g_lsb
            assign cin = control[2];
        end else begin : g_chain
            assign cin = g_slice[i-1].cout;
        end

        alu1 u_bit (
            .a       (a[i]),
            .b       (b[i]),
            .cin     (cin),
            .less    ((i == 0) ? set_lt : 1'b0),
            .control (control),
            .result  (res),
            .cout    (cout)
        );

        assign result[i] = res;
    end

    // Set-less-than takes the sign of A-B from the MSB sum; overflow is ignored.
    assign set_lt          = a[3] ^ b[3] ^ control[2] ^ g_slice[3].cin;
    // The MSB carry out is not exported.
    assign unused_msb_cout = g_slice[3].cout;
    assign zero            = (result == 4'd0);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one 4-bit ALU between two requesters
//                with registered operands/results, valid/ready handshakes and
//                a response timeout that frees the ALU from a stalled sink.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter import alu_pkg::*; #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_b1,
    input  logic [2:0] req_op0,
    input  logic [2:0] req_op1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_timeout,
    output logic       busy
);

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    logic       rr_last;
    logic       gnt_id;
    logic       grant;
    logic       any_req;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic [3:0] tmo_cnt;
    logic [3:0] alu_result;
    logic       alu_zero;

    assign any_req = |req_valid;
    assign grant   = rr_pick(req_valid, rr_last);
    assign busy    = (state != IDLE);

    // Acceptance is offered in the same IDLE cycle; held off while in reset.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state == IDLE) && any_req) begin
            req_ready[grant] = 1'b1;
        end
    end

    alu u_alu (
        .a       (a_q),
        .b       (b_q),
        .control (op_q),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    // Grant, execute, respond; the response is dropped after TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            gnt_id      <= 1'b0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            op_q        <= 3'd0;
            tmo_cnt     <= 4'd0;
            rsp_valid   <= 2'b00;
            rsp_result  <= 4'd0;
            rsp_zero    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id  <= grant;
                        rr_last <= grant;
                        a_q     <= grant ? req_a1  : req_a0;
                        b_q     <= grant ? req_b1  : req_b0;
                        op_q    <= grant ? req_op1 : req_op0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    tmo_cnt    <= 4'd0;
                    rsp_valid  <= gnt_id ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    // Accept beats an expiry landing in the same cycle.
                    if (rsp_ready[gnt_id]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_valid   <= 2'b00;
                        rsp_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
